// File: rtl/regfile_wb_demux_4x32_pkg.sv
// Shared definitions for the operand register bank: data width, register
// select encodings and the write-back entry carried through the FIFO.
package regfile_wb_demux_4x32_pkg;

  localparam int DATA_W = 32;

  // Destination encodings; the operand selector decodes the same values.
  localparam logic [1:0] SEL_R0 = 2'b00;
  localparam logic [1:0] SEL_R1 = 2'b01;
  localparam logic [1:0] SEL_R2 = 2'b10;
  localparam logic [1:0] SEL_R3 = 2'b11;

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot strobe for a destination select.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wb_demux_4x32_wb_fifo_2.sv
// Two-entry synchronous FIFO of pending write-backs. The 1-bit pointers wrap
// modulo 2; a separate count keeps full and empty unambiguous.
module wb_fifo_2
  import regfile_wb_demux_4x32_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic [1:0] count,
  output logic      full,
  output logic      empty
);

  wb_entry_t [1:0] mem_q, mem_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  // Guard internally so a stray request can never over/underflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state: write at tail, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any pending entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_demux_4x32.sv
// Write-back distributor for the 4-register operand bank: queues incoming
// results, retires one per unstalled cycle into r0..r3 and strobes wr_en.
module regfile_wb_demux_4x32
  import regfile_wb_demux_4x32_pkg::*;
#(
  parameter int DATA_W = regfile_wb_demux_4x32_pkg::DATA_W,  // must match package width
  parameter int DEPTH  = 2                                   // only 2 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_select,
  input  logic              wb_stall,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [3:0]        wr_en,
  output logic [1:0]        fill_level
);

  wb_entry_t               push_entry, head;
  logic                    push, pop, full, empty;
  logic [1:0]              count;
  logic [3:0][DATA_W-1:0]  regs_q, regs_d;
  logic [3:0]              wr_en_q, wr_en_d;

  // Ready comes from the registered count only, never from a same-cycle pop.
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = !empty && !wb_stall;
  assign push_entry = '{sel: in_select, data: in_data};

  wb_fifo_2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Retire decode: the head entry updates exactly one register.
  always_comb begin
    regs_d  = regs_q;
    wr_en_d = 4'b0000;
    if (pop) begin
      regs_d[head.sel] = head.data;
      wr_en_d          = sel_onehot(head.sel);
    end
  end

  // Register bank and registered write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      wr_en_q <= 4'b0000;
    end else begin
      regs_q  <= regs_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign r0         = regs_q[SEL_R0];
  assign r1         = regs_q[SEL_R1];
  assign r2         = regs_q[SEL_R2];
  assign r3         = regs_q[SEL_R3];
  assign wr_en      = wr_en_q;
  assign fill_level = count;

endmodule

// File: doc/regfile_wb_demux_4x32.md
Name: regfile_wb_demux_4x32

Overview:
- Write-back side of the 4-register operand bank: the distributor that fills r0..r3, which the 4-to-1 operand selector reads.
- Accepts a 32-bit result plus a 2-bit destination select over a valid/ready handshake.
- Buffers up to two pending writes in a small FIFO.
- Retires one write per cycle into the selected register and pulses a one-hot write strobe.

Parameters:
- DATA_W, 32, width of data and of each register.
- DEPTH, 2, pending-write FIFO depth. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a write to offer.
- in_ready  output  1  block can accept a write this cycle.
- in_data  input  DATA_W  value to write.
- in_select  input  2  destination: 00=r0, 01=r1, 10=r2, 11=r3.
- wb_stall  input  1  downstream hold; when 1, no FIFO entry retires this cycle.
- r0  output  DATA_W  register 0 contents.
- r1  output  DATA_W  register 1 contents.
- r2  output  DATA_W  register 2 contents.
- r3  output  DATA_W  register 3 contents.
- wr_en  output  4  one-hot strobe; bit k=1 for exactly one cycle after rk is written.
- fill_level  output  2  number of pending entries, 0..2.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - r0..r3 = 0, wr_en = 0000, fill_level = 0, FIFO pointers = 0.
  - Pending entries are discarded, including in mid-operation; none retire after reset.
  - in_ready = 1 once rst_n is high.
- Push:
  - in_ready = (fill_level < 2). It is a function of registered count only and never depends on a same-cycle pop.
  - A transfer occurs when in_valid and in_ready are both 1 at a rising edge.
  - {in_select, in_data} is captured at the tail.
  - in_valid while in_ready=0 is ignored; the producer must hold its data.
- Pop:
  - At a rising edge where fill_level > 0 and wb_stall = 0, the head entry retires: r[sel] <= data, and the head pointer advances.
  - Exactly one register changes per retire; the other three hold.
- wr_en:
  - Registered. After a retire edge, wr_en = one-hot(sel) for one cycle, else 0000.
  - Consecutive retires give back-to-back strobes.
- Latency: a write accepted at edge N into an empty, unstalled FIFO is visible on rX after edge N+1, with wr_en asserted in the same cycle. There is no bypass path from in_data to rX.
- Simultaneous push and pop:
  - fill_level 1, push + pop → stays 1, FIFO order preserved.
  - fill_level 2 → no push (in_ready=0); a pop drops the level to 1.
- Back-to-back writes to the same register retire in order; the last one wins.
- wb_stall held → FIFO fills to 2 and stalls the producer; r0..r3 and wr_en hold 0.
- Pointers are 1 bit each and wrap modulo 2; the count is separate. Full and empty are never ambiguous.

Decomposition:
- Shared package: DATA_W, the select encodings SEL_R0..SEL_R3 (2'b00..2'b11), and the wb entry struct {sel[1:0], data[DATA_W-1:0]}.
  - The operand selector uses the same encodings.
- One sub-module: wb_fifo_2, the 2-entry synchronous FIFO with push/pop/count.
- The top level holds the decode, register bank and strobe.

Test Plan:
- Reset mid-operation: reset with 2 entries pending → r0..r3=0, wr_en=0000, fill_level=0, in_ready=1; no later write appears.
- Single write: in_data=0xDEADBEEF, sel=10, stall=0 → after the next edge r2=0xDEADBEEF, wr_en=0100 for 1 cycle; r0/r1/r3 unchanged.
- Stall fill: stall=1, push 0x11 (sel 00) then 0x22 (sel 01) → fill_level=2, in_ready=0, third offer held.
  - Release stall → r0=0x11, then r1=0x22 on consecutive cycles; wr_en 0001 then 0010.
- Streaming: stall=0, in_valid every cycle with 0x1..0x8 cycling sel 00..11 → one retire per cycle, fill_level ≤1, final r0=5, r1=6, r2=7, r3=8.
- Same-register ordering: push 0xAAAA then 0xBBBB to sel 11 → r3 ends 0xBBBB; wr_en=1000 on two consecutive cycles.
- Full + pop: fill_level=2, stall drops while in_valid=1 → pop occurs, push refused that cycle, accepted the next cycle.
